// File: rtl/rob_pkg.sv
// Shared ROB completion types: a completion record carries the ROB index, the mispredict flag and the corrected PC.
package rob_pkg;
  localparam int ROB_INDEX_SIZE = 7;
  localparam int NUM_REQ_DEF    = 3;
  localparam int PC_W           = 16;

  typedef struct packed {
    logic [ROB_INDEX_SIZE-1:0] index;
    logic                      mispred;
    logic [PC_W-1:0]           new_pc;
  } cmpl_t;
endpackage

// File: rtl/cmpl_fifo.sv
// Per-requester completion FIFO: pushed entries are visible at the head one cycle later.
// The caller guards push with count < DEPTH; clear empties it regardless of push/pop.
module cmpl_fifo
  import rob_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          i_clear,
  input  logic          i_push,
  input  cmpl_t         i_dat,
  input  logic          i_pop,
  output cmpl_t         o_head,
  output logic [CW-1:0] o_count
);
  cmpl_t         r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(i_push) - CW'(i_pop);
    end
  end

  // Payload storage needs no reset: only entries counted by r_count are ever read.
  always_ff @(posedge CLK) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/rob_wb_arbiter.sv
// Merges NUM_REQ completion streams onto two registered ROB writeback ports, round-robin, 2 cycles push-to-WB.
// Each requester sees Ready only while its FIFO has room by registered count; Flush drops everything.
module rob_wb_arbiter #(
  parameter int NUM_REQ        = rob_pkg::NUM_REQ_DEF,
  parameter int ROB_INDEX_SIZE = rob_pkg::ROB_INDEX_SIZE,
  parameter int FIFO_DEPTH     = 2
) (
  input  logic                              CLK,
  input  logic                              RST_N,
  input  logic                              Flush,
  input  logic [NUM_REQ-1:0]                REQ_V,
  input  logic [NUM_REQ*ROB_INDEX_SIZE-1:0] REQ_Index,
  input  logic [NUM_REQ-1:0]                REQ_Mispred,
  input  logic [NUM_REQ*16-1:0]             REQ_New_PC,
  output logic [NUM_REQ-1:0]                REQ_Ready,
  output logic                              WB1_V,
  output logic [ROB_INDEX_SIZE-1:0]         WB1_Index,
  output logic                              WB1_Mispred,
  output logic [15:0]                       WB1_New_PC,
  output logic                              WB2_V,
  output logic [ROB_INDEX_SIZE-1:0]         WB2_Index,
  output logic                              WB2_Mispred,
  output logic [15:0]                       WB2_New_PC,
  output logic                              Busy
);
  import rob_pkg::*;

  localparam int PW = $clog2(NUM_REQ);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  cmpl_t                w_in    [NUM_REQ];
  cmpl_t                w_head  [NUM_REQ];
  logic [CW-1:0]        w_count [NUM_REQ];
  logic [NUM_REQ-1:0]   w_push;
  logic [NUM_REQ-1:0]   w_pop;
  logic [NUM_REQ-1:0]   w_nonempty;
  logic                 w_g0_vld, w_g1_vld;
  logic [PW-1:0]        w_g0, w_g1, w_rr_nxt;
  logic [PW-1:0]        r_rr_ptr;
  logic                 r_wb1_v, r_wb2_v;
  cmpl_t                r_wb1, r_wb2;

  function automatic logic [PW-1:0] rot(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return PW'(s);
  endfunction

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_in[g] = '{index:   REQ_Index[g*ROB_INDEX_SIZE +: ROB_INDEX_SIZE],
                       mispred: REQ_Mispred[g],
                       new_pc:  REQ_New_PC[g*16 +: 16]};
    assign REQ_Ready[g]  = ~Flush & (w_count[g] < CW'(FIFO_DEPTH));
    assign w_push[g]     = REQ_V[g] & REQ_Ready[g];
    assign w_nonempty[g] = |w_count[g];
    assign w_pop[g]      = (w_g0_vld && (w_g0 == PW'(g))) || (w_g1_vld && (w_g1 == PW'(g)));

    cmpl_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .i_clear (Flush),
      .i_push  (w_push[g]),
      .i_dat   (w_in[g]),
      .i_pop   (w_pop[g]),
      .o_head  (w_head[g]),
      .o_count (w_count[g])
    );
  end

  // Cyclic scan from rr_ptr: first non-empty head feeds WB1, second feeds WB2.
  always_comb begin
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0     = '0;
    w_g1     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_nonempty[rot(r_rr_ptr, i)]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0     = rot(r_rr_ptr, i);
        end else if (!w_g1_vld) begin
          w_g1_vld = 1'b1;
          w_g1     = rot(r_rr_ptr, i);
        end
      end
    end
    w_rr_nxt = rot(w_g1_vld ? w_g1 : w_g0, 1);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_rr_ptr <= '0;
      r_wb1_v  <= 1'b0;
      r_wb2_v  <= 1'b0;
      r_wb1    <= '0;
      r_wb2    <= '0;
    end else if (Flush) begin
      r_rr_ptr <= '0;
      r_wb1_v  <= 1'b0;
      r_wb2_v  <= 1'b0;
      r_wb1    <= '0;
      r_wb2    <= '0;
    end else begin
      if (w_g0_vld) r_rr_ptr <= w_rr_nxt;
      r_wb1_v <= w_g0_vld;
      r_wb2_v <= w_g1_vld;
      r_wb1   <= w_g0_vld ? w_head[w_g0] : '0;
      r_wb2   <= w_g1_vld ? w_head[w_g1] : '0;
    end
  end

  assign WB1_V       = r_wb1_v;
  assign WB1_Index   = r_wb1.index;
  assign WB1_Mispred = r_wb1.mispred;
  assign WB1_New_PC  = r_wb1.new_pc;
  assign WB2_V       = r_wb2_v;
  assign WB2_Index   = r_wb2.index;
  assign WB2_Mispred = r_wb2.mispred;
  assign WB2_New_PC  = r_wb2.new_pc;
  assign Busy        = (|w_nonempty) | r_wb1_v | r_wb2_v;
endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Bench for rob_wb_arbiter: directed vector table, reset/flush sequences, saturation and random traffic vs a queue model.
module tb_rob_wb_arbiter;
  import rob_pkg::*;

  localparam int NR    = 3;
  localparam int RIS   = 7;
  localparam int DEPTH = 2;

  logic              CLK = 1'b0;
  logic              clk_en = 1'b1;
  logic              RST_N = 1'b0;
  logic              Flush = 1'b0;
  logic [NR-1:0]     REQ_V = '0;
  logic [NR*RIS-1:0] REQ_Index = '0;
  logic [NR-1:0]     REQ_Mispred = '0;
  logic [NR*16-1:0]  REQ_New_PC = '0;
  logic [NR-1:0]     REQ_Ready;
  logic              WB1_V, WB1_Mispred, WB2_V, WB2_Mispred, Busy;
  logic [RIS-1:0]    WB1_Index, WB2_Index;
  logic [15:0]       WB1_New_PC, WB2_New_PC;

  rob_wb_arbiter #(.NUM_REQ(NR), .ROB_INDEX_SIZE(RIS), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST_N(RST_N), .Flush(Flush),
    .REQ_V(REQ_V), .REQ_Index(REQ_Index), .REQ_Mispred(REQ_Mispred), .REQ_New_PC(REQ_New_PC),
    .REQ_Ready(REQ_Ready),
    .WB1_V(WB1_V), .WB1_Index(WB1_Index), .WB1_Mispred(WB1_Mispred), .WB1_New_PC(WB1_New_PC),
    .WB2_V(WB2_V), .WB2_Index(WB2_Index), .WB2_Mispred(WB2_Mispred), .WB2_New_PC(WB2_New_PC),
    .Busy(Busy)
  );

  always #5 if (clk_en) CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: one queue per requester ----------------
  cmpl_t         mq [NR][$];
  int            m_rr = 0;
  logic [NR-1:0] e_ready, m_acc;
  logic          e_v1, e_v2;
  cmpl_t         e_wb1, e_wb2;

  function automatic cmpl_t in_pay(input int r);
    cmpl_t c;
    c.index   = REQ_Index[r*RIS +: RIS];
    c.mispred = REQ_Mispred[r];
    c.new_pc  = REQ_New_PC[r*16 +: 16];
    return c;
  endfunction

  task automatic model_edge();
    int g[$];
    for (int r = 0; r < NR; r++) e_ready[r] = !Flush && (mq[r].size() < DEPTH);
    m_acc = REQ_V & e_ready;
    for (int i = 0; i < NR; i++) begin
      int r;
      r = (m_rr + i) % NR;
      if (mq[r].size() > 0 && g.size() < 2) g.push_back(r);
    end
    e_v1 = 1'b0; e_v2 = 1'b0; e_wb1 = '0; e_wb2 = '0;
    if (Flush) begin
      for (int r = 0; r < NR; r++) mq[r].delete();
      m_rr = 0;
    end else begin
      if (g.size() > 0) begin e_v1 = 1'b1; e_wb1 = mq[g[0]].pop_front(); end
      if (g.size() > 1) begin e_v2 = 1'b1; e_wb2 = mq[g[1]].pop_front(); end
      for (int r = 0; r < NR; r++) if (m_acc[r]) mq[r].push_back(in_pay(r));
      if (g.size() > 0) m_rr = (g[g.size()-1] + 1) % NR;
    end
  endtask

  function automatic logic m_busy();
    logic b;
    b = e_v1 | e_v2;
    for (int r = 0; r < NR; r++) if (mq[r].size() > 0) b = 1'b1;
    return b;
  endfunction

  // Called at posedge+1 with inputs already driven; ends at the next posedge+1.
  task automatic run_cycle(input string tag);
    #1;
    model_edge();
    chk({tag, "_ready"}, 32'(REQ_Ready), 32'(e_ready));
    @(posedge CLK); #1;
    chk({tag, "_wb1"}, {WB1_V, WB1_Index, WB1_Mispred, WB1_New_PC}, {e_v1, e_wb1});
    chk({tag, "_wb2"}, {WB2_V, WB2_Index, WB2_Mispred, WB2_New_PC}, {e_v2, e_wb2});
    chk({tag, "_busy"}, 32'(Busy), 32'(m_busy()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic fl; logic [2:0] v; logic [20:0] idx; logic [2:0] mp; logic [47:0] pc; logic [2:0] er;
    logic e1v; logic [6:0] e1i; logic e1m; logic [15:0] e1p;
    logic e2v; logic [6:0] e2i; logic e2m; logic [15:0] e2p; logic eb;
  } vec_t;
  vec_t tbl [10];

  int            next_k [NR];
  int            wait_c [NR];
  int            max_w  [NR];
  logic [NR-1:0] rdy_dropped;
  logic [NR-1:0] pend;
  logic [NR-1:0] pre_ne, granted;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 3'b001, {7'd0, 7'd0, 7'd5}, 3'b000, {16'h0, 16'h0, 16'h0040}, 3'b111,
               0, 7'd0, 0, 16'h0, 0, 7'd0, 0, 16'h0, 1};
    tbl[1] = '{0, 3'b000, 21'd0, 3'b000, 48'd0, 3'b111,
               1, 7'd5, 0, 16'h0040, 0, 7'd0, 0, 16'h0, 1};
    tbl[2] = '{1, 3'b000, 21'd0, 3'b000, 48'd0, 3'b000,
               0, 7'd0, 0, 16'h0, 0, 7'd0, 0, 16'h0, 0};
    tbl[3] = '{0, 3'b111, {7'd12, 7'd11, 7'd10}, 3'b000, {16'h1002, 16'h1001, 16'h1000}, 3'b111,
               0, 7'd0, 0, 16'h0, 0, 7'd0, 0, 16'h0, 1};
    tbl[4] = '{0, 3'b000, 21'd0, 3'b000, 48'd0, 3'b111,
               1, 7'd10, 0, 16'h1000, 1, 7'd11, 0, 16'h1001, 1};
    tbl[5] = '{0, 3'b000, 21'd0, 3'b000, 48'd0, 3'b111,
               1, 7'd12, 0, 16'h1002, 0, 7'd0, 0, 16'h0, 1};
    tbl[6] = '{0, 3'b101, {7'd30, 7'd0, 7'd31}, 3'b000, {16'h2002, 16'h0, 16'h2001}, 3'b111,
               0, 7'd0, 0, 16'h0, 0, 7'd0, 0, 16'h0, 1};
    tbl[7] = '{0, 3'b100, {7'd127, 7'd0, 7'd0}, 3'b100, {16'hBEEF, 16'h0, 16'h0}, 3'b111,
               1, 7'd31, 0, 16'h2001, 1, 7'd30, 0, 16'h2002, 1};
    tbl[8] = '{0, 3'b000, 21'd0, 3'b000, 48'd0, 3'b111,
               1, 7'd127, 1, 16'hBEEF, 0, 7'd0, 0, 16'h0, 1};
    tbl[9] = '{0, 3'b000, 21'd0, 3'b000, 48'd0, 3'b111,
               0, 7'd0, 0, 16'h0, 0, 7'd0, 0, 16'h0, 0};

    // Power-on reset state
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_wb1", {WB1_V, WB1_Index, WB1_Mispred, WB1_New_PC}, 32'd0);
    chk("rst_wb2", {WB2_V, WB2_Index, WB2_Mispred, WB2_New_PC}, 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_ready", 32'(REQ_Ready), 32'b111);
    RST_N = 1'b1;

    for (int k = 0; k < 10; k++) begin
      Flush = tbl[k].fl; REQ_V = tbl[k].v; REQ_Index = tbl[k].idx;
      REQ_Mispred = tbl[k].mp; REQ_New_PC = tbl[k].pc;
      #1;
      chk($sformatf("tbl%0d_ready", k), 32'(REQ_Ready), 32'(tbl[k].er));
      @(posedge CLK); #1;
      chk($sformatf("tbl%0d_wb1", k), {WB1_V, WB1_Index, WB1_Mispred, WB1_New_PC},
          {tbl[k].e1v, tbl[k].e1i, tbl[k].e1m, tbl[k].e1p});
      chk($sformatf("tbl%0d_wb2", k), {WB2_V, WB2_Index, WB2_Mispred, WB2_New_PC},
          {tbl[k].e2v, tbl[k].e2i, tbl[k].e2m, tbl[k].e2p});
      chk($sformatf("tbl%0d_busy", k), 32'(Busy), 32'(tbl[k].eb));
    end

    // Reset mid-stream with the clock stopped
    Flush = 1'b0; REQ_Mispred = '0; REQ_New_PC = '0;
    REQ_V = 3'b111; REQ_Index = {7'd3, 7'd2, 7'd1};
    @(posedge CLK); #1;
    REQ_V = '0;
    @(posedge CLK); #1;
    chk("mid_pre_wb1v", 32'(WB1_V), 32'd1);
    chk("mid_pre_busy", 32'(Busy), 32'd1);
    clk_en = 1'b0;
    #2; RST_N = 1'b0;
    #1;
    chk("mid_rst_wbv", {WB1_V, WB2_V}, 32'd0);
    chk("mid_rst_busy", 32'(Busy), 32'd0);
    #3; RST_N = 1'b1;
    #4; clk_en = 1'b1;
    @(posedge CLK); #1;
    chk("mid_post_ready", 32'(REQ_Ready), 32'b111);
    chk("mid_post_busy", 32'(Busy), 32'd0);

    // Saturation: every requester always has a completion pending
    rdy_dropped = '0;
    for (int r = 0; r < NR; r++) begin next_k[r] = 0; wait_c[r] = 0; max_w[r] = 0; end
    for (int c = 0; c < 16; c++) begin
      REQ_V = (c < 12) ? 3'b111 : 3'b000;
      for (int r = 0; r < NR; r++) begin
        REQ_Index[r*RIS +: RIS] = 7'(r*40 + next_k[r]);
        REQ_New_PC[r*16 +: 16]  = 16'(r*256 + next_k[r]);
        pre_ne[r] = (mq[r].size() > 0);
      end
      run_cycle($sformatf("sat%0d", c));
      rdy_dropped = rdy_dropped | ~REQ_Ready;
      for (int r = 0; r < NR; r++) begin
        if (m_acc[r]) next_k[r]++;
        granted[r] = (WB1_V && (int'(WB1_Index) / 40 == r)) || (WB2_V && (int'(WB2_Index) / 40 == r));
        wait_c[r] = (pre_ne[r] && !granted[r]) ? wait_c[r] + 1 : 0;
        if (wait_c[r] > max_w[r]) max_w[r] = wait_c[r];
      end
      if (c >= 1 && c < 12) chk($sformatf("sat%0d_two_wb", c), 32'(int'(WB1_V) + int'(WB2_V)), 32'd2);
    end
    for (int r = 0; r < NR; r++) chk($sformatf("sat_max_wait_r%0d", r), 32'(max_w[r]), 32'(max_w[r] <= 1 ? max_w[r] : 1));
    chk("sat_ready_dropped", 32'(rdy_dropped), 32'b111);

    // Flush with four completions queued and all requesters pushing
    for (int c = 0; c < 2; c++) begin
      REQ_V = 3'b111;
      for (int r = 0; r < NR; r++) REQ_Index[r*RIS +: RIS] = 7'(100 + c*3 + r);
      run_cycle($sformatf("fill%0d", c));
    end
    Flush = 1'b1; REQ_V = 3'b111;
    for (int r = 0; r < NR; r++) REQ_Index[r*RIS +: RIS] = 7'(110 + r);
    run_cycle("flush");
    chk("flush_wbv", {WB1_V, WB2_V}, 32'd0);
    chk("flush_busy", 32'(Busy), 32'd0);
    Flush = 1'b0; REQ_V = '0;
    run_cycle("post_flush0");
    run_cycle("post_flush1");
    REQ_V = 3'b111;
    for (int r = 0; r < NR; r++) REQ_Index[r*RIS +: RIS] = 7'(120 + r);
    run_cycle("pf_push");
    REQ_V = '0;
    run_cycle("pf_grant");
    chk("pf_first_r0", {WB1_V, WB1_Index, WB2_V, WB2_Index}, {1'b1, 7'd120, 1'b1, 7'd121});
    run_cycle("pf_drain0");
    run_cycle("pf_drain1");

    // Random traffic with occasional flushes; requesters hold payload until accepted
    pend = '0;
    for (int c = 0; c < 400; c++) begin
      for (int r = 0; r < NR; r++) begin
        if (!pend[r] && $urandom_range(0, 3) != 0) begin
          pend[r] = 1'b1;
          REQ_Index[r*RIS +: RIS] = 7'($urandom);
          REQ_Mispred[r]          = 1'($urandom);
          REQ_New_PC[r*16 +: 16]  = 16'($urandom);
        end
      end
      REQ_V = pend;
      Flush = ($urandom_range(0, 19) == 0);
      run_cycle("rnd");
      pend = pend & ~m_acc;
    end
    Flush = 1'b0; REQ_V = '0;
    for (int c = 0; c < 4; c++) run_cycle("rnd_drain");
    chk("end_busy", 32'(Busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
